// File: rtl/key_scan_ctrl.sv
`timescale 1ns/1ps
// key_scan_ctrl: sequenced row scanner for a ROWS x COLS key matrix with
// shared-schedule hysteresis debounce and a press/release event FIFO.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   row_o         row drive, active-low, one-cold
//   col_i         column sense, active-low, asynchronous
//   key_state     debounced level per key, index row*COLS+col
//   evt_valid     event FIFO head valid
//   evt_ready     consumer accept
//   evt_code      key index of head event
//   evt_press     1 = press, 0 = release
//   ovf           sticky: an event was dropped on a full FIFO
//
// Build option: KEY_RELEASE_EVT_EN queues release events as well as
// presses; without it only presses are queued and evt_press is tied 1.
module key_scan_ctrl #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 5,
    parameter  int SCAN_DIV   = 50000,
    parameter  int DEB_MAX    = 3,
    parameter  int FIFO_DEPTH = 4,
    localparam int KW         = $clog2(ROWS * COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ROWS-1:0]        row_o,
    input  logic [COLS-1:0]        col_i,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [KW-1:0]          evt_code,
    output logic                   evt_press,
    output logic                   ovf
);

    localparam int NK   = ROWS * COLS;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CMAX = (SCAN_DIV > COLS) ? SCAN_DIV : COLS;
    localparam int CW   = $clog2(CMAX);
    localparam int DW   = $clog2(DEB_MAX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
`ifdef KEY_RELEASE_EVT_EN
    localparam int EW   = KW + 1;
`else
    localparam int EW   = KW;
`endif

    typedef enum logic [1:0] {
        S_DWELL,
        S_LATCH,
        S_UPDATE,
        S_ADVANCE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [COLS-1:0]  sync1_q, sync2_q, col_q;
    logic [NK-1:0]    key_state_q;
    logic [DW-1:0]    integ_q [NK];

    logic             latch_en, upd_en;
    logic [KW-1:0]    key_idx;
    logic [COLS-1:0]  col_shift;
    logic             col_bit;
    logic [DW-1:0]    integ_cur, integ_nxt;
    logic             ks_cur, rise, fall;
    logic             push;
    logic [EW-1:0]    push_data;

    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic             ovf_q;
    logic             full, empty, pop, wr_en, drop;
    logic [EW-1:0]    head;

    // State register, scan counters and debounce state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DWELL;
            cnt_q       <= '0;
            row_idx_q   <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            col_q       <= '0;
            key_state_q <= '0;
            for (int i = 0; i < NK; i++) integ_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_idx_q <= row_idx_d;
            sync1_q   <= col_i;
            sync2_q   <= sync1_q;
            if (latch_en) col_q <= ~sync2_q;
            if (upd_en) begin
                integ_q[key_idx] <= integ_nxt;
                if (rise)      key_state_q[key_idx] <= 1'b1;
                else if (fall) key_state_q[key_idx] <= 1'b0;
            end
        end
    end

    // Next-state logic; cnt counts dwell cycles, then columns in UPDATE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        row_idx_d = row_idx_q;
        unique case (state_q)
            S_DWELL: begin
                if (cnt_q == CW'(SCAN_DIV - 1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                state_d = S_UPDATE;
                cnt_d   = '0;
            end
            S_UPDATE: begin
                if (cnt_q == CW'(COLS - 1)) begin
                    state_d = S_ADVANCE;
                    cnt_d   = '0;
                end
            end
            S_ADVANCE: begin
                state_d   = S_DWELL;
                cnt_d     = '0;
                row_idx_d = (row_idx_q == RW'(ROWS - 1)) ?
                            '0 : row_idx_q + RW'(1);
            end
            default: begin
                state_d = S_DWELL;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        row_o    = ~(ROWS'(1) << row_idx_q);
        latch_en = (state_q == S_LATCH);
        upd_en   = (state_q == S_UPDATE);
    end

    // One key per UPDATE cycle: saturating integrator with hysteresis
    always_comb begin
        key_idx   = upd_en ?
                    KW'(int'(row_idx_q) * COLS + int'(cnt_q)) : '0;
        col_shift = col_q >> cnt_q;
        col_bit   = col_shift[0];
        integ_cur = integ_q[key_idx];
        if (col_bit)
            integ_nxt = (integ_cur == DW'(DEB_MAX)) ?
                        integ_cur : integ_cur + DW'(1);
        else
            integ_nxt = (integ_cur == '0) ?
                        integ_cur : integ_cur - DW'(1);
        ks_cur = key_state_q[key_idx];
        rise   = upd_en & ~ks_cur & (integ_nxt == DW'(DEB_MAX));
        fall   = upd_en &  ks_cur & (integ_nxt == '0);
`ifdef KEY_RELEASE_EVT_EN
        push      = rise | fall;
        push_data = {rise, key_idx};
`else
        push      = rise;
        push_data = key_idx;
`endif
    end

    // Event FIFO; a full FIFO still accepts a push when it pops that cycle
    always_comb begin
        empty = (wr_q == rd_q);
        full  = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
        pop   = ~empty & evt_ready;
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
        head  = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= push_data;
                wr_q <= wr_q + PW'(1);
            end
            if (pop)  rd_q  <= rd_q + PW'(1);
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign key_state = key_state_q;
    assign evt_valid = ~empty;
    assign evt_code  = head[KW-1:0];
`ifdef KEY_RELEASE_EVT_EN
    assign evt_press = head[KW];
`else
    assign evt_press = 1'b1;
`endif
    assign ovf = ovf_q;

endmodule
